issue_queue: RTL

//  Parametrised in-order issue buffer between decode and the execution units; next generation of the single-slot issue stage.

---
 rtl/issue_queue.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/issue_queue.sv
// In-order issue buffer with a per-register busy scoreboard and NUM_FU valid/ready dispatch channels.
// Optional performance counters are enabled by defining ISSUE_QUEUE_PERF_EN.
module issue_queue #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 64,
    parameter int NUM_FU    = 2,
    localparam int FU_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int PW       = $clog2(DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_enq_valid,
    output logic                 o_enq_ready,
    input  logic [PAYLOAD_W-1:0] i_enq_payload,
    input  logic [FU_W-1:0]      i_enq_fu,
    input  logic [4:0]           i_enq_rs1,
    input  logic [4:0]           i_enq_rs2,
    input  logic                 i_enq_uses_rs1,
    input  logic                 i_enq_uses_rs2,
    input  logic [4:0]           i_enq_rd,
    input  logic                 i_enq_writes_rd,
    input  logic                 i_wb_en,
    input  logic [4:0]           i_wb_rd,
    output logic [NUM_FU-1:0]    o_fu_valid,
    input  logic [NUM_FU-1:0]    i_fu_ready,
    output logic [PAYLOAD_W-1:0] o_fu_payload,
    output logic [CW-1:0]        o_count
`ifdef ISSUE_QUEUE_PERF_EN
    ,
    output logic [31:0]          o_perf_issued,
    output logic [31:0]          o_perf_hazard_stalls
`endif
);

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [FU_W-1:0]      fu;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic                 uses_rs1;
        logic                 uses_rs2;
        logic [4:0]           rd;
        logic                 writes_rd;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_busy;

    entry_t          w_head;
    logic            w_empty;
    logic            w_full;
    logic            w_enq;
    logic            w_deq;
    logic            w_rs1_block;
    logic            w_rs2_block;
    logic            w_head_ok;
    logic [NUM_FU-1:0] w_fu_valid;
    logic [31:0]     w_wb_mask;
    logic [31:0]     w_set_mask;
    logic [31:0]     w_busy_next;

    assign w_head      = r_mem[r_head];
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    assign o_enq_ready = !w_full;
    assign o_count     = r_count;
    assign w_enq       = i_enq_valid && !w_full && !i_flush;

    // A writeback landing this cycle already satisfies a waiting source.
    assign w_rs1_block = w_head.uses_rs1 && r_busy[w_head.rs1] && !(i_wb_en && (i_wb_rd == w_head.rs1));
    assign w_rs2_block = w_head.uses_rs2 && r_busy[w_head.rs2] && !(i_wb_en && (i_wb_rd == w_head.rs2));
    assign w_head_ok   = !w_empty && !w_rs1_block && !w_rs2_block;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_fu_valid = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_fu_valid[i] = w_head_ok && !i_flush && (int'(w_head.fu) == i);
        end
    end

    assign o_fu_valid   = w_fu_valid;
    assign w_deq        = |(w_fu_valid & i_fu_ready);
    assign o_fu_payload = w_empty ? '0 : w_head.payload;

    always_comb begin
        w_wb_mask  = '0;
        w_set_mask = '0;
        if (i_wb_en) begin
            w_wb_mask[i_wb_rd] = 1'b1;
        end
        if (w_deq && w_head.writes_rd) begin
            w_set_mask[w_head.rd] = 1'b1;
        end
        // Set after clear so a new producer wins over a retiring one; x0 is never busy.
        w_busy_next = ((r_busy & ~w_wb_mask) | w_set_mask) & ~32'h1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_busy  <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (i_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq) r_tail <= r_tail + PW'(1);
                if (w_deq) r_head <= r_head + PW'(1);
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // NOTE: the entry array has no reset; r_count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= '{payload:   i_enq_payload,
                               fu:        i_enq_fu,
                               rs1:       i_enq_rs1,
                               rs2:       i_enq_rs2,
                               uses_rs1:  i_enq_uses_rs1,
                               uses_rs2:  i_enq_uses_rs2,
                               rd:        i_enq_rd,
                               writes_rd: i_enq_writes_rd};
        end
    end

`ifdef ISSUE_QUEUE_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_hazard_stalls;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_issued        <= '0;
            r_perf_hazard_stalls <= '0;
        end else begin
            if (w_deq) r_perf_issued <= r_perf_issued + 32'd1;
            if (!w_empty && !w_head_ok) r_perf_hazard_stalls <= r_perf_hazard_stalls + 32'd1;
        end
    end

    assign o_perf_issued        = r_perf_issued;
    assign o_perf_hazard_stalls = r_perf_hazard_stalls;
`endif

`ifndef SYNTHESIS
    // An out-of-range unit index would park the op at head forever.
    always @(posedge clk) begin
        if (!rst && w_enq) begin
            assert (int'(i_enq_fu) < NUM_FU)
            else $error("issue_queue: enqueue with unit index %0d out of range", i_enq_fu);
        end
    end
`endif

endmodule
